// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - LED pattern sequencer and arbiter driving an LED PIO slave
// Optional feature macro: LED_SEQ_BOUNCE_EN (adds mode 2, a bouncing single lit bit)

module led_pattern_sequencer #(
   parameter int PERIOD_W = 24,
   parameter int LED_W    = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  s_address,
   input  logic        s_chipselect,
   input  logic        s_write_n,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata,
   output logic [1:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [31:0] m_writedata,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_WAIT = 2'd2,
      ST_STEP = 2'd3
   } state_t;

   // CSR word addresses
   localparam logic [1:0] A_CTRL    = 2'd0;
   localparam logic [1:0] A_PERIOD  = 2'd1;
   localparam logic [1:0] A_PATTERN = 2'd2;
   localparam logic [1:0] A_DIRECT  = 2'd3;

   state_t              state_q, state_d;
   logic                enable_q, enable_d;
   logic [1:0]          mode_q, mode_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] presc_q, presc_d;
   logic [LED_W-1:0]    pattern_q, pattern_d;
   logic [15:0]         step_count_q, step_count_d;
   logic                pending_q, pending_d;
   logic                m_cs_q, m_cs_d;
   logic [LED_W-1:0]    m_data_q, m_data_d;
`ifdef LED_SEQ_BOUNCE_EN
   logic                dir_q, dir_d;      // 0 = walking left, 1 = walking right
   logic                dir_next;
`endif

   logic                csr_wr;
   logic                ctrl_wr;
   logic                period_wr;
   logic                pattern_wr;
   logic                direct_wr;
   logic                en_next;
   logic [PERIOD_W-1:0] reload;
   logic [LED_W-1:0]    base;
   logic [LED_W-1:0]    step_val;
   logic                compute;
   logic                seq_wr;
   logic                unused_wdata;

   assign csr_wr     = s_chipselect && !s_write_n;
   assign ctrl_wr    = csr_wr && (s_address == A_CTRL);
   assign period_wr  = csr_wr && (s_address == A_PERIOD);
   assign pattern_wr = csr_wr && (s_address == A_PATTERN);
   assign direct_wr  = csr_wr && (s_address == A_DIRECT);

   // Enable as it will be after this cycle; state changes follow it so busy drops the cycle after a disable
   assign en_next = ctrl_wr ? s_writedata[0] : enable_q;

   // The LOAD/STEP cycle is the first tick of a period, so the countdown starts one below PERIOD-1
   assign reload = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);

   // Write-data bits that no register keeps
   assign unused_wdata = ^s_writedata;

   // Working pattern seen by this cycle's step: a DIRECT or PATTERN write replaces it first
   always_comb begin
      base = pattern_q;
      if (pattern_wr) base = s_writedata[LED_W-1:0];
      if (direct_wr)  base = s_writedata[LED_W-1:0];
   end

   // Next pattern for the selected mode; unsupported codes rotate left
   always_comb begin
      step_val = {base[LED_W-2:0], base[LED_W-1]};
`ifdef LED_SEQ_BOUNCE_EN
      dir_next = dir_q;
`endif
      case (mode_q)
         2'd1: step_val = ~base;
`ifdef LED_SEQ_BOUNCE_EN
         2'd2: begin
            if (!dir_q) begin
               if (base[LED_W-1]) begin
                  step_val = base >> 1;
                  dir_next = 1'b1;
               end else begin
                  step_val = base << 1;
               end
            end else begin
               if (base[0]) begin
                  step_val = base << 1;
                  dir_next = 1'b0;
               end else begin
                  step_val = base >> 1;
               end
            end
         end
`endif
         default: ;
      endcase
   end

   // Sequencer FSM: next state, prescaler, step counter and whether the sequencer wants the PIO
   always_comb begin
      state_d      = state_q;
      presc_d      = presc_q;
      step_count_d = step_count_q;
      compute      = 1'b0;
      seq_wr       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en_next) state_d = ST_LOAD;
         end
         ST_LOAD, ST_STEP: begin
            seq_wr = 1'b1;
            if (state_q == ST_STEP) begin
               step_count_d = step_count_q + 16'd1;
               // A DIRECT stealing this slot restarts the step from the DIRECT value
               compute = direct_wr;
            end
            if (reload == '0) begin
               compute = 1'b1;
               state_d = ST_STEP;
            end else begin
               presc_d = reload - PERIOD_W'(1);
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (presc_q == '0) begin
               compute = 1'b1;
               state_d = ST_STEP;
            end else begin
               presc_d = presc_q - PERIOD_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A write held back by DIRECT goes out now; it merges with a STEP write of the same cycle
      if (pending_q) seq_wr = 1'b1;
      if ((state_q != ST_IDLE) && !en_next) begin
         state_d = ST_IDLE;
         compute = 1'b0;
      end
   end

   // CSR updates, pattern update and PIO arbitration (DIRECT first, sequencer write held one cycle)
   always_comb begin
      enable_d  = en_next;
      mode_d    = ctrl_wr ? s_writedata[2:1] : mode_q;
      period_d  = period_wr ? s_writedata[PERIOD_W-1:0] : period_q;
      pattern_d = compute ? step_val : base;
`ifdef LED_SEQ_BOUNCE_EN
      dir_d     = compute ? dir_next : dir_q;
`endif
      pending_d = en_next && direct_wr && seq_wr;
      m_cs_d    = direct_wr || seq_wr;
      m_data_d  = m_data_q;
      if (direct_wr) begin
         m_data_d = s_writedata[LED_W-1:0];
      end else if (seq_wr) begin
         m_data_d = pattern_q;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         enable_q     <= 1'b0;
         mode_q       <= 2'd0;
         period_q     <= PERIOD_W'(1);
         presc_q      <= '0;
         pattern_q    <= '0;
         step_count_q <= 16'd0;
         pending_q    <= 1'b0;
         m_cs_q       <= 1'b0;
         m_data_q     <= '0;
`ifdef LED_SEQ_BOUNCE_EN
         dir_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         enable_q     <= enable_d;
         mode_q       <= mode_d;
         period_q     <= period_d;
         presc_q      <= presc_d;
         pattern_q    <= pattern_d;
         step_count_q <= step_count_d;
         pending_q    <= pending_d;
         m_cs_q       <= m_cs_d;
         m_data_q     <= m_data_d;
`ifdef LED_SEQ_BOUNCE_EN
         dir_q        <= dir_d;
`endif
      end
   end

   assign busy         = (state_q != ST_IDLE);
   assign m_address    = 2'b00;
   assign m_chipselect = m_cs_q;
   assign m_write_n    = ~m_cs_q;
   assign m_writedata  = 32'(m_data_q);

   // Zero-latency CSR read mux
   always_comb begin
      s_readdata = 32'd0;
      case (s_address)
         A_CTRL:    s_readdata = {29'd0, mode_q, enable_q};
         A_PERIOD:  s_readdata = 32'(period_q);
         A_PATTERN: s_readdata = 32'(pattern_q);
         A_DIRECT:  s_readdata = {14'd0, busy, pending_q, step_count_q};
         default:   s_readdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - self-checking bench for led_pattern_sequencer

module tb_led_pattern_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  s_address;
   logic        s_chipselect;
   logic        s_write_n;
   logic [31:0] s_writedata;
   logic [31:0] s_readdata;
   logic [1:0]  m_address;
   logic        m_chipselect;
   logic        m_write_n;
   logic [31:0] m_writedata;
   logic        busy;

   led_pattern_sequencer #(.PERIOD_W(24), .LED_W(8)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .s_address    (s_address),
      .s_chipselect (s_chipselect),
      .s_write_n    (s_write_n),
      .s_writedata  (s_writedata),
      .s_readdata   (s_readdata),
      .m_address    (m_address),
      .m_chipselect (m_chipselect),
      .m_write_n    (m_write_n),
      .m_writedata  (m_writedata),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] data;
      int         at;
   } exp_wr_t;

   exp_wr_t sb_q[$];

   typedef struct {
      logic [1:0]  waddr;
      logic [31:0] wdata;
      logic [1:0]  raddr;
      logic [31:0] exp_rd;
      logic        exp_pio;
      logic [7:0]  pio;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_wr(input logic [7:0] d, input int at);
      exp_wr_t e;
      e.data = d;
      e.at   = at;
      sb_q.push_back(e);
   endtask

   task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
      s_address    = a;
      s_writedata  = d;
      s_chipselect = 1'b1;
      s_write_n    = 1'b0;
      @(posedge clk);
      #1;
      s_chipselect = 1'b0;
      s_write_n    = 1'b1;
   endtask

   task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
      s_address    = a;
      s_chipselect = 1'b1;
      s_write_n    = 1'b1;
      #1;
      d = s_readdata;
      s_chipselect = 1'b0;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_drain(input string name);
      check(name, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   // PIO monitor: every strobe must match the next expected write in value and cycle
   always @(negedge clk) begin : monitor
      exp_wr_t e;
      check("pio_strobe_pair", {31'd0, m_write_n}, {31'd0, ~m_chipselect});
      if (m_chipselect && !m_write_n) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pio_unexpected: got write 0x%0h at cycle %0d, expected no write", m_writedata, cyc);
         end else begin
            e = sb_q.pop_front();
            check("pio_data", m_writedata, {24'd0, e.data});
            check("pio_cycle", 32'(cyc), 32'(e.at));
            check("pio_address", {30'd0, m_address}, 32'd0);
         end
      end
   end

   initial begin : watchdog
      #50000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin : main
      int          n;
      logic [31:0] rd;

      reset_n      = 1'b0;
      s_address    = 2'd0;
      s_chipselect = 1'b0;
      s_write_n    = 1'b1;
      s_writedata  = 32'd0;

      vecs[0] = '{2'd1, 32'h0012_3456, 2'd1, 32'h0012_3456, 1'b0, 8'h00};
      vecs[1] = '{2'd1, 32'hFFFF_FFFF, 2'd1, 32'h00FF_FFFF, 1'b0, 8'h00};
      vecs[2] = '{2'd1, 32'h0000_0000, 2'd1, 32'h0000_0000, 1'b0, 8'h00};
      vecs[3] = '{2'd2, 32'hABCD_01FF, 2'd2, 32'h0000_00FF, 1'b0, 8'h00};
      vecs[4] = '{2'd0, 32'h0000_0006, 2'd0, 32'h0000_0006, 1'b0, 8'h00};
      vecs[5] = '{2'd0, 32'hFFFF_FFF8, 2'd0, 32'h0000_0000, 1'b0, 8'h00};
      vecs[6] = '{2'd3, 32'h1234_565A, 2'd2, 32'h0000_005A, 1'b1, 8'h5A};
      vecs[7] = '{2'd3, 32'h0000_0081, 2'd3, 32'h0000_0000, 1'b1, 8'h81};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_chipselect", {31'd0, m_chipselect}, 32'd0);
      check("rst_m_write_n", {31'd0, m_write_n}, 32'd1);
      check("rst_m_writedata", m_writedata, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      csr_read(2'd0, rd); check("rst_ctrl", rd, 32'd0);
      csr_read(2'd1, rd); check("rst_period", rd, 32'd1);
      csr_read(2'd3, rd); check("rst_status", rd, 32'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // CSR write/readback and idle DIRECT writes
      for (int i = 0; i < 8; i++) begin
         n = cyc;
         if (vecs[i].exp_pio) expect_wr(vecs[i].pio, n + 1);
         csr_write(vecs[i].waddr, vecs[i].wdata);
         csr_read(vecs[i].raddr, rd);
         check($sformatf("csr_vec%0d", i), rd, vecs[i].exp_rd);
      end
      repeat (2) @(posedge clk);
      #1;
      check_drain("drain_csr_table");

      // Rotate-left, PERIOD=4, then disable during WAIT
      csr_write(2'd2, 32'h01);
      csr_write(2'd1, 32'd4);
      n = cyc;
      expect_wr(8'h01, n + 2);
      expect_wr(8'h02, n + 6);
      expect_wr(8'h04, n + 10);
      expect_wr(8'h08, n + 14);
      csr_write(2'd0, 32'h1);
      check("rot_busy_load", {31'd0, busy}, 32'd1);
      wait_cyc(n + 15);
      check("rot_busy_before_off", {31'd0, busy}, 32'd1);
      csr_write(2'd0, 32'h0);
      check("rot_busy_after_off", {31'd0, busy}, 32'd0);
      csr_read(2'd3, rd); check("rot_status", rd, 32'd3);
      wait_cyc(n + 24);
      check_drain("drain_rotate");

      // Re-enable: LOAD writes the current pattern
      n = cyc;
      expect_wr(8'h08, n + 2);
      expect_wr(8'h10, n + 6);
      csr_write(2'd0, 32'h1);
      wait_cyc(n + 7);
      csr_write(2'd0, 32'h0);
      wait_cyc(n + 14);
      check_drain("drain_reenable");

      // Invert mode, PERIOD=0: a write every cycle
      csr_write(2'd2, 32'hA5);
      csr_write(2'd1, 32'd0);
      n = cyc;
      expect_wr(8'hA5, n + 2);
      expect_wr(8'h5A, n + 3);
      expect_wr(8'hA5, n + 4);
      expect_wr(8'h5A, n + 5);
      expect_wr(8'hA5, n + 6);
      csr_write(2'd0, 32'h3);
      wait_cyc(n + 5);
      csr_write(2'd0, 32'h2);
      check("inv_busy_after_off", {31'd0, busy}, 32'd0);
      csr_read(2'd3, rd); check("inv_status", rd, 32'd8);
      csr_read(2'd2, rd); check("inv_pattern", rd, 32'hA5);
      wait_cyc(n + 10);
      check_drain("drain_invert");

      // DIRECT collides with a STEP write: DIRECT first, held write carries the rotated DIRECT value
      csr_write(2'd2, 32'h01);
      csr_write(2'd1, 32'd4);
      n = cyc;
      expect_wr(8'h01, n + 2);
      expect_wr(8'h02, n + 6);
      expect_wr(8'h3C, n + 10);
      expect_wr(8'h78, n + 11);
      expect_wr(8'hF0, n + 14);
      expect_wr(8'hE1, n + 18);
      csr_write(2'd0, 32'h1);
      wait_cyc(n + 9);
      csr_write(2'd3, 32'h3C);
      csr_read(2'd3, rd); check("col_pending_set", 32'(rd[17:16]), 32'd3);
      @(posedge clk);
      #1;
      csr_read(2'd3, rd); check("col_pending_clr", 32'(rd[17:16]), 32'd2);
      wait_cyc(n + 19);
      csr_write(2'd0, 32'h0);
      wait_cyc(n + 26);
      check_drain("drain_collision");

      // Mode 2 with PERIOD=1
      csr_write(2'd2, 32'h40);
      csr_write(2'd1, 32'd1);
      n = cyc;
      expect_wr(8'h40, n + 2);
      expect_wr(8'h80, n + 3);
`ifdef LED_SEQ_BOUNCE_EN
      expect_wr(8'h40, n + 4);
      expect_wr(8'h20, n + 5);
`else
      expect_wr(8'h01, n + 4);
      expect_wr(8'h02, n + 5);
`endif
      csr_write(2'd0, 32'h5);
      csr_read(2'd0, rd); check("mode2_ctrl", rd, 32'h5);
      wait_cyc(n + 4);
      csr_write(2'd0, 32'h4);
      wait_cyc(n + 9);
      check_drain("drain_mode2");

      // Asynchronous reset in the middle of WAIT
      csr_write(2'd2, 32'h81);
      csr_write(2'd1, 32'd8);
      n = cyc;
      expect_wr(8'h81, n + 2);
      csr_write(2'd0, 32'h1);
      wait_cyc(n + 5);
      #1;
      reset_n = 1'b0;
      #1;
      check("mid_rst_m_chipselect", {31'd0, m_chipselect}, 32'd0);
      check("mid_rst_m_write_n", {31'd0, m_write_n}, 32'd1);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      csr_read(2'd3, rd); check("mid_rst_status", rd, 32'd0);
      csr_read(2'd1, rd); check("mid_rst_period", rd, 32'd1);
      reset_n = 1'b1;
      wait_cyc(n + 20);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      check_drain("drain_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Controller that sequences the 8-bit LED PIO slave (address/chipselect/write_n/writedata, zero-wait single-cycle writes).
- Host software (HPS via lightweight bridge) configures it through a small Avalon-MM CSR slave.
- The block autonomously steps an LED pattern at a programmable rate and issues the PIO writes itself.
- It also arbitrates a direct software LED write against the sequencer so both share the one PIO.

Parameters:
- PERIOD_W, 24, width of the step-period register (ticks of clk per step)
- LED_W, 8, pattern/LED width; must equal PIO data width

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- s_address  in  2  CSR word address
- s_chipselect  in  1  CSR select
- s_write_n  in  1  CSR write strobe, active-low
- s_writedata  in  32  CSR write data
- s_readdata  out  32  CSR read data, combinational, zero read latency
- m_address  out  2  PIO address, constant 0
- m_chipselect  out  1  PIO select
- m_write_n  out  1  PIO write strobe, active-low
- m_writedata  out  32  PIO write data, LED value in [LED_W-1:0], upper bits 0
- busy  out  1  high while sequencer enabled (state != IDLE)

Behaviour:
- Reset: clk is the only clock; reset_n is asynchronous, active-low.
  - All registers clear; PERIOD resets to 1.
  - m_chipselect=0, m_write_n=1, m_writedata=0, busy=0, s_readdata reflects reset CSR values.
- CSR map (write when s_chipselect && !s_write_n):
  - 0 CTRL: [0] enable, [2:1] mode.
  - 1 PERIOD: [PERIOD_W-1:0].
  - 2 PATTERN: [LED_W-1:0] seed; writing reloads the working pattern.
  - 3 DIRECT: [LED_W-1:0]; writing requests an immediate override PIO write.
  - Reads: 0 CTRL, 1 PERIOD, 2 current working pattern, 3 STATUS = {busy, pending, step_count[15:0]} at [17],[16],[15:0]. Unused bits read 0.
- Modes (unsupported codes behave as mode 0):
  - 0 rotate-left by 1.
  - 1 invert.
- PERIOD=0 is treated as 1: steps every cycle.
- FSM:
  - IDLE: enable=0, no writes except DIRECT. On enable rising, go to LOAD.
  - LOAD: 1 cycle. Issue PIO write of the working pattern, load prescaler with PERIOD-1, go to WAIT.
  - WAIT: prescaler decrements each cycle. At 0, compute next pattern and go to STEP.
  - STEP: 1 cycle. Issue PIO write of the new pattern, step_count+1 (wraps 0xFFFF->0), reload prescaler, return to WAIT.
  - enable=0 in any state: go to IDLE next cycle. A write issued in that same cycle still completes; no further writes.
- PIO write = exactly one cycle with m_chipselect=1, m_write_n=0, m_writedata valid; otherwise m_chipselect=0, m_write_n=1.
- PIO outputs are registered: a write is on the master port the cycle after the decision.
- Arbitration:
  - DIRECT has priority. Its PIO write appears 1 cycle after the CSR write.
  - A DIRECT write also sets the working pattern to the DIRECT value, so the sequencer continues from it.
  - If a LOAD/STEP write coincides with a pending DIRECT write, DIRECT goes first. The sequencer write is held in a 1-deep pending flag and issued the following cycle with the updated pattern. The prescaler is not delayed.
  - A second DIRECT write while one is pending overwrites the value; only one write is issued.
- PATTERN write while running takes effect at the next STEP computation; no immediate PIO write.
- PERIOD write while running takes effect at the next prescaler reload.
- Back-to-back writes: with PERIOD=1 (or 0), a PIO write occurs every cycle.

Optional Feature:
- LED_SEQ_BOUNCE_EN:
  - When defined, mode 2 = bounce: a single lit bit walks left to MSB, then right to LSB, reversing at each end without repeating the end position. A direction bit resets to left. CTRL read returns mode 2.
  - When undefined, mode 2 behaves as mode 0 and no direction register exists.

Test Plan:
- Reset with reset_n=0 mid-WAIT -> m_chipselect=0, m_write_n=1, busy=0, STATUS=0, PERIOD reads 1.
- PATTERN=0x01, PERIOD=4, CTRL=0x1 -> PIO write 0x01, then writes 0x02, 0x04, 0x08 exactly 4 cycles apart; step_count=3.
- Mode 1, PATTERN=0xA5, PERIOD=0 -> PIO writes alternate 0x5A/0xA5 every cycle, each a 1-cycle strobe.
- DIRECT=0x3C written the cycle a STEP write is due -> PIO sees 0x3C, then next cycle 0x78 (rotated from 0x3C); prescaler cadence unchanged.
- Clear enable during WAIT -> no further PIO writes, busy=0 next cycle; re-enable -> LOAD writes current pattern.
- With LED_SEQ_BOUNCE_EN, mode 2, seed 0x40, PERIOD=1 -> 0x40, 0x80, 0x40, 0x20; without the macro -> 0x40, 0x80, 0x01.
